// File: rtl/muldiv_sequencer.sv
// Sequencer for the shared iterative multiply/divide unit and its HiLo register pair.
// Latency: unit_load one cycle after acceptance, hilo_we ITER+2 cycles after it (2 on divide-by-zero).
// Backpressure: op_ready only in IDLE; MULTU/DIVU/MFHI/MFLO presented while busy raise stall.
//
// Ports:
//   clk, reset         clock and synchronous active-high reset
//   op_valid, funct    function code handshake (MULTU=25, DIVU=27, MFHI=16, MFLO=18)
//   divisor_zero       divisor operand is zero, sampled when a DIVU is accepted
//   op_ready, busy     idle / operation in flight
//   stall              issuing stage must hold its instruction (combinational)
//   unit_load          one-cycle operand load pulse to the iterative unit
//   unit_step          one unit iteration per cycle while high
//   unit_sel           0 = multiply, 1 = divide
//   iter_cnt           iteration index while stepping, else 0
//   hilo_we, dz_flag   HiLo write pulse and divide-by-zero marker
//   mf_sel             HiLo read-mux select for an accepted MFHI (01) / MFLO (10)
module muldiv_sequencer #(
   parameter int ITER  = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             op_valid,
   input  logic [5:0]       funct,
   input  logic             divisor_zero,
   output logic             op_ready,
   output logic             busy,
   output logic             stall,
   output logic             unit_load,
   output logic             unit_step,
   output logic             unit_sel,
   output logic [CNT_W-1:0] iter_cnt,
   output logic             hilo_we,
   output logic             dz_flag,
   output logic [1:0]       mf_sel
);

   localparam logic [5:0] F_MULTU = 6'd25;
   localparam logic [5:0] F_DIVU  = 6'd27;
   localparam logic [5:0] F_MFHI  = 6'd16;
   localparam logic [5:0] F_MFLO  = 6'd18;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_RUN   = 2'd2,
      S_WRITE = 2'd3
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic             sel_q;
   logic             dz_q;
   logic [CNT_W-1:0] cnt_q;

   logic is_mul;
   logic is_div;
   logic is_mfhi;
   logic is_mflo;
   logic cnt_last;

   assign is_mul   = op_valid && (funct == F_MULTU);
   assign is_div   = op_valid && (funct == F_DIVU);
   assign is_mfhi  = op_valid && (funct == F_MFHI);
   assign is_mflo  = op_valid && (funct == F_MFLO);
   assign cnt_last = (cnt_q == CNT_LAST);

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Operation context: unit select, divide-by-zero latch, iteration counter.
   // unit_sel only changes at acceptance so it stays stable from LOAD through WRITE.
   always_ff @(posedge clk) begin
      if (reset) begin
         sel_q <= 1'b0;
         dz_q  <= 1'b0;
         cnt_q <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (is_mul) begin
                  sel_q <= 1'b0;
               end else if (is_div) begin
                  sel_q <= 1'b1;
                  dz_q  <= divisor_zero;
               end
            end
            S_RUN: begin
               cnt_q <= cnt_last ? '0 : cnt_q + CNT_W'(1);
            end
            S_WRITE: begin
               dz_q <= 1'b0;
            end
            default: begin
            end
         endcase
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (is_mul || is_div) state_nxt = S_LOAD;
         S_LOAD:  state_nxt = dz_q ? S_WRITE : S_RUN;
         S_RUN:   if (cnt_last) state_nxt = S_WRITE;
         S_WRITE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Outputs decoded from registered state; stall and mf_sel also look at the live request.
   // WRITE is treated as busy so a HiLo read waits until the new result is visible.
   always_comb begin
      op_ready  = 1'b0;
      busy      = 1'b0;
      unit_load = 1'b0;
      unit_step = 1'b0;
      hilo_we   = 1'b0;
      dz_flag   = 1'b0;
      case (state)
         S_IDLE:  op_ready = 1'b1;
         S_LOAD: begin
            busy      = 1'b1;
            unit_load = 1'b1;
         end
         S_RUN: begin
            busy      = 1'b1;
            unit_step = 1'b1;
         end
         S_WRITE: begin
            busy    = 1'b1;
            hilo_we = 1'b1;
            dz_flag = dz_q;
         end
         default: begin
         end
      endcase
      stall  = (is_mul || is_div || is_mfhi || is_mflo) && (state != S_IDLE);
      mf_sel = 2'b00;
      if (state == S_IDLE) begin
         if (is_mfhi)      mf_sel = 2'b01;
         else if (is_mflo) mf_sel = 2'b10;
      end
   end

   assign unit_sel = sel_q;
   assign iter_cnt = cnt_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

   localparam int ITER  = 32;
   localparam int CNT_W = 6;

   localparam logic [5:0] F_MULTU = 6'd25;
   localparam logic [5:0] F_DIVU  = 6'd27;
   localparam logic [5:0] F_MFHI  = 6'd16;
   localparam logic [5:0] F_MFLO  = 6'd18;
   localparam logic [5:0] F_ADD   = 6'd32;
   localparam logic [5:0] F_SRL   = 6'd2;
   localparam logic [5:0] F_NONE  = 6'd0;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             op_valid = 1'b0;
   logic [5:0]       funct = 6'd0;
   logic             divisor_zero = 1'b0;
   logic             op_ready;
   logic             busy;
   logic             stall;
   logic             unit_load;
   logic             unit_step;
   logic             unit_sel;
   logic [CNT_W-1:0] iter_cnt;
   logic             hilo_we;
   logic             dz_flag;
   logic [1:0]       mf_sel;

   muldiv_sequencer #(.ITER(ITER), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .reset        (reset),
      .op_valid     (op_valid),
      .funct        (funct),
      .divisor_zero (divisor_zero),
      .op_ready     (op_ready),
      .busy         (busy),
      .stall        (stall),
      .unit_load    (unit_load),
      .unit_step    (unit_step),
      .unit_sel     (unit_sel),
      .iter_cnt     (iter_cnt),
      .hilo_we      (hilo_we),
      .dz_flag      (dz_flag),
      .mf_sel       (mf_sel)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: k = cycles elapsed since the acceptance edge (0 = idle).
   int k     = 0;
   bit m_sel = 1'b0;
   bit m_dz  = 1'b0;
   int n_we  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, check every output mid-cycle, then advance the model.
   task automatic step(input bit v, input logic [5:0] f, input bit dzin, input bit rst);
      int  len;
      bit  bsy;
      bit  cls;
      bit  run;
      op_valid     = v;
      funct        = f;
      divisor_zero = dzin;
      reset        = rst;
      @(negedge clk);
      len = m_dz ? 2 : ITER + 2;
      bsy = (k != 0);
      run = !m_dz && (k >= 2) && (k <= ITER + 1);
      cls = v && (f == F_MULTU || f == F_DIVU || f == F_MFHI || f == F_MFLO);
      chk("op_ready",  {31'd0, op_ready},  {31'd0, !bsy});
      chk("busy",      {31'd0, busy},      {31'd0, bsy});
      chk("unit_load", {31'd0, unit_load}, {31'd0, k == 1});
      chk("unit_step", {31'd0, unit_step}, {31'd0, run});
      chk("iter_cnt",  {26'd0, iter_cnt},  run ? 32'(k - 2) : 32'd0);
      chk("hilo_we",   {31'd0, hilo_we},   {31'd0, bsy && k == len});
      chk("dz_flag",   {31'd0, dz_flag},   {31'd0, bsy && k == len && m_dz});
      chk("unit_sel",  {31'd0, unit_sel},  {31'd0, m_sel});
      chk("stall",     {31'd0, stall},     {31'd0, cls && bsy});
      chk("mf_sel",    {30'd0, mf_sel},
          (!bsy && v && f == F_MFHI) ? 32'd1 : (!bsy && v && f == F_MFLO) ? 32'd2 : 32'd0);
      if (hilo_we === 1'b1) n_we++;
      @(posedge clk);
      #1;
      if (rst) begin
         k = 0; m_sel = 1'b0; m_dz = 1'b0;
      end else if (k != 0) begin
         k = (k == len) ? 0 : k + 1;
      end else if (v && (f == F_MULTU || f == F_DIVU)) begin
         k = 1; m_sel = (f == F_DIVU); m_dz = (f == F_DIVU) && dzin;
      end
   endtask

   logic [5:0] ftab [8];

   initial begin
      int we0;
      ftab[0] = F_MULTU; ftab[1] = F_DIVU; ftab[2] = F_MFHI; ftab[3] = F_MFLO;
      ftab[4] = F_ADD;   ftab[5] = F_SRL;  ftab[6] = F_NONE; ftab[7] = F_NONE;

      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      step(0, F_NONE, 0, 1);
      step(0, F_NONE, 0, 0);

      // MULTU, full run
      we0 = n_we;
      step(1, F_MULTU, 0, 0);
      repeat (36) step(0, F_NONE, 0, 0);
      chk("multu_we_count", 32'(n_we - we0), 32'd1);

      // DIVU, nonzero divisor
      step(1, F_DIVU, 0, 0);
      repeat (36) step(0, F_NONE, 0, 0);

      // DIVU, divide-by-zero bypass
      we0 = n_we;
      step(1, F_DIVU, 1, 0);
      repeat (4) step(0, F_NONE, 0, 0);
      chk("dz_we_count", 32'(n_we - we0), 32'd1);

      // MFLO held from cycle 5 of a MULTU
      step(1, F_MULTU, 0, 0);
      repeat (4) step(0, F_NONE, 0, 0);
      repeat (32) step(1, F_MFLO, 0, 0);
      step(0, F_NONE, 0, 0);

      // Unrelated functs during RUN
      step(1, F_MULTU, 0, 0);
      for (int i = 0; i < 36; i++) step(1, (i % 2 == 0) ? F_ADD : F_SRL, 0, 0);

      // Reset while iter_cnt == 10, then a fresh MULTU
      we0 = n_we;
      step(1, F_MULTU, 0, 0);
      repeat (11) step(0, F_NONE, 0, 0);
      step(0, F_NONE, 0, 1);
      repeat (3) step(0, F_NONE, 0, 0);
      chk("abort_no_we", 32'(n_we - we0), 32'd0);
      step(1, F_MULTU, 0, 0);
      repeat (36) step(0, F_NONE, 0, 0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic [5:0] f;
         int idx;
         idx = int'($urandom_range(0, 7));
         f   = (idx >= 6) ? 6'($urandom) : ftab[idx];
         step($urandom_range(0, 3) != 0, f, $urandom_range(0, 3) == 0,
              $urandom_range(0, 199) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle controller for the shared iterative multiply/divide unit and the HiLo register pair behind the ALU/shifter/MUL function-code dispatch.
- Accepts a 6-bit funct code with a valid handshake and sequences MULTU/DIVU: operand load, ITER step cycles, then a single HiLo write.
- Generates the stall seen by the issuing stage when MULTU/DIVU/MFHI/MFLO collide with an operation in flight.

Parameters:
- ITER, 32, number of step cycles per MULTU/DIVU (must be >= 1, <= 63).
- CNT_W, 6, width of iter_cnt (must hold ITER-1).

Ports:
- clk  in  1  clock, all state updates on posedge.
- reset  in  1  synchronous, active-high; sampled on posedge clk.
- op_valid  in  1  funct is presented this cycle.
- funct  in  6  function code: MULTU=6'd25, DIVU=6'd27, MFHI=6'd16, MFLO=6'd18; all others ignored.
- divisor_zero  in  1  divisor operand is zero; sampled only at DIVU acceptance.
- op_ready  out  1  sequencer idle, can accept MULTU/DIVU.
- busy  out  1  high in LOAD, RUN and WRITE.
- stall  out  1  issuing stage must hold its instruction this cycle.
- unit_load  out  1  one-cycle pulse: unit latches operands, clears partial result.
- unit_step  out  1  unit performs one iteration this cycle.
- unit_sel  out  1  0 = multiply, 1 = divide; stable from LOAD through WRITE.
- iter_cnt  out  CNT_W  current iteration index during RUN, else 0.
- hilo_we  out  1  one-cycle pulse: HiLo captures unit result.
- dz_flag  out  1  high with hilo_we when DIVU completed by divide-by-zero bypass.
- mf_sel  out  2  2'b01 = Hi, 2'b10 = Lo, 2'b00 = none; read-mux select for an accepted MFHI/MFLO.

Behaviour:
- All outputs registered or decoded from registered state only, except stall and mf_sel, which are combinational from op_valid, funct and state.
- Reset values: state=IDLE, op_ready=1, busy=0, unit_load=0, unit_step=0, unit_sel=0, iter_cnt=0, hilo_we=0, dz_flag=0, dz latch=0.
- States:
  - IDLE:
    - op_valid with MULTU: unit_sel<=0, go LOAD.
    - op_valid with DIVU: unit_sel<=1, latch dz=divisor_zero, go LOAD.
    - All other functs: no state change.
  - LOAD (1 cycle):
    - unit_load=1, iter_cnt=0.
    - Next state: WRITE if dz, else RUN.
  - RUN (ITER cycles):
    - unit_step=1; iter_cnt counts 0..ITER-1, one step per cycle.
    - When iter_cnt==ITER-1: go WRITE, iter_cnt<=0.
  - WRITE (1 cycle):
    - hilo_we=1, dz_flag=dz.
    - Clear dz, go IDLE.
- Latency: with acceptance edge = E0, unit_load is high in the cycle after E0. hilo_we is high in cycle ITER+2 after E0 (normal), or cycle 2 (divide-by-zero bypass).
- op_ready=1 only in IDLE. No back-to-back accept: the earliest next MULTU/DIVU acceptance is the edge ending the cycle after WRITE.
- stall=1 when op_valid and funct is MULTU, DIVU, MFHI or MFLO and state!=IDLE. Other functs never stall.
- mf_sel is non-zero only when op_valid, state==IDLE and funct is MFHI or MFLO; otherwise 2'b00.
- WRITE counts as not IDLE, so an MFHI/MFLO presented during WRITE stalls one more cycle. This guarantees the read sees the new HiLo.
- op_valid/funct changes during LOAD/RUN/WRITE do not affect the sequence in flight.
- Reset asserted in any state: next cycle all outputs take reset values. No hilo_we is issued for the aborted operation.
- Unknown funct codes never change state, never stall, never drive unit signals.

Test Plan:
- Reset, then MULTU accepted (ITER=32):
  - unit_load high exactly 1 cycle, then unit_step high 32 consecutive cycles with iter_cnt 0..31.
  - hilo_we high at cycle 34 after acceptance edge; unit_sel=0 throughout; op_ready returns 1 at cycle 35.
- DIVU with divisor_zero=0:
  - Same timing as MULTU with unit_sel=1; dz_flag=0 at hilo_we.
- DIVU with divisor_zero=1:
  - unit_load at cycle 1, no unit_step pulses.
  - hilo_we and dz_flag both high at cycle 2; idle at cycle 3.
- MFLO held on op_valid from cycle 5 of a MULTU:
  - stall=1 and mf_sel=00 through the WRITE cycle.
  - Next cycle stall=0 and mf_sel=10.
- funct=ADD (6'd32) and SRL (6'd2) issued during RUN: stall=0, step count unaffected, hilo_we still at cycle 34.
- Reset asserted at iter_cnt=10:
  - Next cycle busy=0, unit_step=0, iter_cnt=0; no hilo_we pulse.
  - A fresh MULTU is accepted and runs the full 32 steps.
